// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_norm normalizer.
package shift_pkg;

  localparam int SN_WIDTH = 32;
  localparam int SN_CNT_W = 6;
  localparam logic [5:0] SN_ZERO_CNT = 6'd32;
  localparam logic [2:0] SN_FIRST_STEP = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/norm_step.sv
// One binary-search step of the normalizer: test the top 2^step bits and shift.
// Signed (redundant-sign) testing is built only with SHIFT_NORM_SIGNED_EN.
module norm_step
  import shift_pkg::*;
(
  input  logic [SN_WIDTH-1:0] word,
  input  logic [2:0]          step,
  input  logic                signed_mode,
  output logic [SN_WIDTH-1:0] next_word,
  output logic [SN_CNT_W-1:0] inc
);

  logic [SN_CNT_W-1:0] n;
  logic                zero_top;
  logic                hit;

  assign n        = 6'd1 << step;
  assign zero_top = ((word >> (6'd32 - n)) == {SN_WIDTH{1'b0}});

`ifdef SHIFT_NORM_SIGNED_EN
  logic [SN_WIDTH-1:0] sra;
  logic                sign_top;

  // Arithmetic shift leaves only the top n+1 bits, sign-extended: all-equal means 0 or all ones.
  assign sra      = $signed(word) >>> (6'd31 - n);
  assign sign_top = (sra == {SN_WIDTH{1'b0}}) || (sra == {SN_WIDTH{1'b1}});
  assign hit      = signed_mode ? sign_top : zero_top;
`else
  logic unused_mode;
  assign unused_mode = signed_mode;
  assign hit         = zero_top;
`endif

  assign next_word = hit ? (word << n) : word;
  assign inc       = hit ? n : {SN_CNT_W{1'b0}};

endmodule

// File: rtl/shift_norm.sv
// Sequential leading-zero / redundant-sign normalizer, one search step per cycle.
// SHIFT_NORM_SIGNED_EN enables signed (redundant-sign) counting via the SIGNED input.
module shift_norm
  import shift_pkg::*;
#(
  parameter int WIDTH = SN_WIDTH,
  parameter int CNT_W = SN_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic             SIGNED,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic [CNT_W-1:0] CNT,
  output logic             ZERO
);

  state_t             state_r;
  state_t             state_n;
  logic               in_ready_s;
  logic               accept_s;
  logic               mode_in_s;
  logic [WIDTH-1:0]   work_r;
  logic [CNT_W-1:0]   acc_r;
  logic [2:0]         k_r;
  logic               signed_r;
  logic               zero_r;
  logic [WIDTH-1:0]   z_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               zero_out_r;
  logic [WIDTH-1:0]   step_word_s;
  logic [CNT_W-1:0]   step_inc_s;
  logic [CNT_W-1:0]   final_cnt_s;

`ifdef SHIFT_NORM_SIGNED_EN
  assign mode_in_s = SIGNED;
`else
  logic unused_signed;
  assign unused_signed = SIGNED;
  assign mode_in_s     = 1'b0;
`endif

  norm_step u_step (
    .word        (work_r),
    .step        (k_r),
    .signed_mode (signed_r),
    .next_word   (step_word_s),
    .inc         (step_inc_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and ready decode; DONE only frees the input when the result retires
  always_comb begin
    state_n    = state_r;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (IN_VALID) state_n = SHIFT;
        else          state_n = IDLE;
      end
      SHIFT: begin
        if (k_r == 3'd0) state_n = DONE;
        else             state_n = SHIFT;
      end
      DONE: begin
        in_ready_s = OUT_READY;
        if (OUT_READY) state_n = IN_VALID ? SHIFT : IDLE;
        else           state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign accept_s    = IN_VALID & in_ready_s;
  assign final_cnt_s = (!signed_r && zero_r) ? SN_ZERO_CNT : (acc_r + step_inc_s);

  // Working datapath and result registers; results load only on the last search step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work_r     <= {WIDTH{1'b0}};
      acc_r      <= {CNT_W{1'b0}};
      k_r        <= SN_FIRST_STEP;
      signed_r   <= 1'b0;
      zero_r     <= 1'b0;
      z_r        <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      zero_out_r <= 1'b0;
    end else if (accept_s) begin
      work_r   <= X;
      acc_r    <= {CNT_W{1'b0}};
      k_r      <= SN_FIRST_STEP;
      signed_r <= mode_in_s;
      zero_r   <= (X == {WIDTH{1'b0}});
    end else if (state_r == SHIFT) begin
      work_r <= step_word_s;
      acc_r  <= acc_r + step_inc_s;
      if (k_r == 3'd0) begin
        k_r        <= SN_FIRST_STEP;
        z_r        <= step_word_s;
        cnt_r      <= final_cnt_s;
        zero_out_r <= zero_r;
      end else begin
        k_r <= k_r - 3'd1;
      end
    end else begin
      work_r <= work_r;
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = (state_r == DONE);
  assign Z         = z_r;
  assign CNT       = cnt_r;
  assign ZERO      = zero_out_r;

endmodule

// File: tb/tb_shift_norm.sv
// Self-checking bench for shift_norm: directed vectors, randomized model checks,
// backpressure, back-to-back throughput and mid-operation reset.
module tb_shift_norm;

`ifdef SHIFT_NORM_SIGNED_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] X;
  logic        SIGNED;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] Z;
  logic [5:0]  CNT;
  logic        ZERO;

  int tests = 0;
  int fails = 0;

  shift_norm dut (
    .clock     (clock),
    .reset     (reset),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .X         (X),
    .SIGNED    (SIGNED),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Z         (Z),
    .CNT       (CNT),
    .ZERO      (ZERO)
  );

  always #5 clock = ~clock;

  // Reference: count leading zeros, or bits after the MSB that repeat it.
  function automatic logic [5:0] ref_cnt(input logic [31:0] x, input logic s);
    int c = 0;
    if (s && SIGN_EN) begin
      while (c < 31 && x[30-c] == x[31]) c++;
    end else begin
      while (c < 32 && x[31-c] == 1'b0) c++;
    end
    return 6'(c);
  endfunction

  function automatic logic [31:0] ref_z(input logic [31:0] x, input logic s);
    logic [5:0] c;
    c = ref_cnt(x, s);
    return (c == 6'd32) ? 32'd0 : (x << c);
  endfunction

  // Issue one operand from IDLE, wait for the result, capture it, then retire it.
  task automatic do_op(input logic [31:0] x, input logic s,
                       output logic [31:0] z, output logic [5:0] c,
                       output logic zr, output int lat);
    @(negedge clock);
    IN_VALID = 1'b1; X = x; SIGNED = s; OUT_READY = 1'b0;
    tests++;
    if (IN_READY !== 1'b1) begin
      fails++; $display("FAIL idle_ready: got %b expected 1", IN_READY);
    end
    @(posedge clock); #1;
    IN_VALID = 1'b0; X = $urandom; SIGNED = $urandom_range(0, 1);
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    z = Z; c = CNT; zr = ZERO;
    @(negedge clock); OUT_READY = 1'b1;
    @(posedge clock); #1; OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    IN_VALID = 1'b0; X = 32'd0; SIGNED = 1'b0; OUT_READY = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || Z !== 32'd0 || CNT !== 6'd0 || ZERO !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b z=%h cnt=%0d zero=%b expected 1 0 0 0 0",
               IN_READY, OUT_VALID, Z, CNT, ZERO);
    end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] dx [6] = '{32'h00010000, 32'h00000000, 32'hFFFFFFF0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    logic        ds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0]  dc [6] = '{6'd15, 6'd32, SIGN_EN ? 6'd27 : 6'd0, SIGN_EN ? 6'd30 : 6'd31,
                            SIGN_EN ? 6'd31 : 6'd0, SIGN_EN ? 6'd31 : 6'd32};
    logic [31:0] dz [6] = '{32'h80000000, 32'h00000000, SIGN_EN ? 32'h80000000 : 32'hFFFFFFF0,
                            SIGN_EN ? 32'h40000000 : 32'h80000000, SIGN_EN ? 32'h80000000 : 32'hFFFFFFFF,
                            32'h00000000};
    logic        dzr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] z; logic [5:0] c; logic zr; int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(dx[i], ds[i], z, c, zr, lat);
      tests++;
      if (c !== dc[i] || z !== dz[i] || zr !== dzr[i] || lat !== 5) begin
        fails++;
        $display("FAIL directed_%0d: got cnt=%0d z=%h zero=%b lat=%0d expected %0d %h %b 5",
                 i, c, z, zr, lat, dc[i], dz[i], dzr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x; logic s; logic [31:0] z; logic [5:0] c; logic zr; int lat;
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = ~x;
      if ($urandom_range(0, 9) == 0) x = 32'd0;
      s = $urandom_range(0, 1);
      do_op(x, s, z, c, zr, lat);
      tests++;
      if (c !== ref_cnt(x, s) || z !== ref_z(x, s) || zr !== (x == 32'd0) || lat !== 5) begin
        fails++;
        $display("FAIL random x=%h s=%b: got cnt=%0d z=%h zero=%b lat=%0d expected %0d %h %b 5",
                 x, s, c, z, zr, lat, ref_cnt(x, s), ref_z(x, s), (x == 32'd0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x0; logic [31:0] z0; logic [5:0] c0; logic zr0; int lat;
    x0 = ($urandom >> $urandom_range(1, 30)) | 32'd1;
    @(negedge clock);
    IN_VALID = 1'b1; X = x0; SIGNED = 1'b0; OUT_READY = 1'b0;
    @(posedge clock); #1; IN_VALID = 1'b0;
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    z0 = Z; c0 = CNT; zr0 = ZERO;
    tests++;
    if (lat !== 5 || c0 !== ref_cnt(x0, 1'b0) || z0 !== ref_z(x0, 1'b0)) begin
      fails++;
      $display("FAIL bp_first: got cnt=%0d z=%h lat=%0d expected %0d %h 5", c0, z0, lat,
               ref_cnt(x0, 1'b0), ref_z(x0, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); IN_VALID = 1'b1; X = $urandom;
      @(posedge clock); #1;
      tests++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || Z !== z0 || CNT !== c0 || ZERO !== zr0) begin
        fails++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b z=%h cnt=%0d expected 1 0 %h %0d",
                 i, OUT_VALID, IN_READY, Z, CNT, z0, c0);
      end
    end
    @(negedge clock);
    OUT_READY = 1'b1; IN_VALID = 1'b1; X = 32'h00F00000; SIGNED = 1'b0;
    #1;
    tests++;
    if (IN_READY !== 1'b1) begin
      fails++; $display("FAIL bp_ready: got %b expected 1", IN_READY);
    end
    @(posedge clock); #1;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    tests++;
    if (OUT_VALID !== 1'b0) begin
      fails++; $display("FAIL bp_retire: got vld=%b expected 0", OUT_VALID);
    end
    lat = 0;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    tests++;
    if (lat !== 5 || CNT !== 6'd8 || Z !== 32'hF0000000 || ZERO !== 1'b0) begin
      fails++;
      $display("FAIL bp_second: got cnt=%0d z=%h lat=%0d expected 8 f0000000 5", CNT, Z, lat);
    end
    @(negedge clock); OUT_READY = 1'b1;
    @(posedge clock); #1; OUT_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [8];
    logic [5:0]  exp_c [$];
    logic [31:0] exp_z [$];
    int issued = 0; int seen = 0; int last = -1; int cyc = 0;
    for (int i = 0; i < 8; i++) ops[i] = $urandom >> $urandom_range(0, 31);
    OUT_READY = 1'b1; SIGNED = 1'b0;
    while (seen < 8 && cyc < 200) begin
      @(negedge clock);
      if (OUT_VALID === 1'b1) begin
        tests++;
        if (exp_c.size() == 0 || CNT !== exp_c[0] || Z !== exp_z[0] || (last >= 0 && cyc - last != 6)) begin
          fails++;
          $display("FAIL b2b_%0d: got cnt=%0d z=%h gap=%0d expected %0d %h 6", seen, CNT, Z, cyc - last,
                   (exp_c.size() > 0) ? exp_c[0] : 6'd0, (exp_z.size() > 0) ? exp_z[0] : 32'd0);
        end
        if (exp_c.size() > 0) begin
          void'(exp_c.pop_front()); void'(exp_z.pop_front());
        end
        last = cyc; seen++;
      end
      IN_VALID = (issued < 8);
      X = (issued < 8) ? ops[issued] : 32'd0;
      #1;
      if (IN_VALID && IN_READY === 1'b1) begin
        exp_c.push_back(ref_cnt(ops[issued], 1'b0));
        exp_z.push_back(ref_z(ops[issued], 1'b0));
        issued++;
      end
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    tests++;
    if (seen != 8) begin
      fails++; $display("FAIL b2b_count: got %0d results expected 8", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z; logic [5:0] c; logic zr; int lat; int bad = 0;
    @(negedge clock);
    IN_VALID = 1'b1; X = 32'h00000100; SIGNED = 1'b0; OUT_READY = 1'b1;
    @(posedge clock); #1; IN_VALID = 1'b0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0; #1;
    tests++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got rdy=%b vld=%b expected 1 0", IN_READY, OUT_VALID);
    end
    repeat (6) begin
      @(posedge clock); #1;
      if (OUT_VALID !== 1'b0) bad++;
    end
    @(negedge clock); reset = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
      if (OUT_VALID !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL reset_abort: got %0d valid cycles expected 0", bad);
    end
    do_op(32'h00F00000, 1'b0, z, c, zr, lat);
    tests++;
    if (c !== 6'd8 || z !== 32'hF0000000 || zr !== 1'b0 || lat !== 5) begin
      fails++;
      $display("FAIL reset_recover: got cnt=%0d z=%h lat=%0d expected 8 f0000000 5", c, z, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
